// File: rtl/lsu_pkg.sv
// Shared types, byte-enable patterns and request legality check for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

    // Load and store encodings share the low funct3 codes (LB/SB, LH/SH, LW/SW).
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_funct3_t;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic req_faults(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_store;
            default:          legal = 1'b0;
        endcase
        misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                     (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data lane select with sign/zero extension.
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
            F3_W:    data_o = rdata_i;
            F3_BU:   data_o = {24'h0, byte_lane};
            F3_HU:   data_o = {16'h0, half_lane};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store unit. Define LSU_TIMEOUT_EN to enable the bus watchdog
// that faults a transaction after TIMEOUT_CYCLES cycles in REQ/WAIT.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_fault_o
);

    lsu_state_t  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        is_store_q;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_data;
    logic        capture;
    logic        timed_out;

    assign req_ready_o = (state_q == IDLE);

    load_align u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (bus_rdata_i),
        .data_o    (load_data)
    );

    always_comb begin
        be_d    = BE_WORD;
        wdata_d = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00: begin
                be_d    = BE_BYTE << req_addr_i[1:0];
                wdata_d = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = req_addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_d = {2{req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // rvalid only counts once the request has been granted.
    assign capture = (state_q == REQ && bus_gnt_i && bus_rvalid_i) ||
                     (state_q == WAIT && bus_rvalid_i);

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q;

    assign timed_out = (state_q == REQ || state_q == WAIT) && (cnt_q == TimeoutLast) && !capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            is_store_q   <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_be_o     <= '0;
            bus_wdata_o  <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_fault_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        funct3_q   <= req_funct3_i;
                        addr_lo_q  <= req_addr_i[1:0];
                        is_store_q <= req_is_store_i;
                        if (req_faults(req_is_store_i, req_funct3_i, req_addr_i[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_fault_o <= 1'b1;
                            resp_data_o  <= '0;
                        end else begin
                            state_q     <= REQ;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= req_is_store_i;
                            bus_addr_o  <= {req_addr_i[31:2], 2'b00};
                            bus_be_o    <= be_d;
                            bus_wdata_o <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: ;
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_o <= 1'b0;
                    resp_fault_o <= 1'b0;
                    resp_data_o  <= '0;
                end
                default: state_q <= IDLE;
            endcase

            // Completion overrides the REQ/WAIT bookkeeping above.
            if (capture) begin
                state_q      <= RESP;
                bus_req_o    <= 1'b0;
                resp_valid_o <= 1'b1;
                resp_fault_o <= 1'b0;
                resp_data_o  <= is_store_q ? 32'h0 : load_data;
            end else if (timed_out) begin
                state_q      <= RESP;
                bus_req_o    <= 1'b0;
                resp_valid_o <= 1'b1;
                resp_fault_o <= 1'b1;
                resp_data_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; inputs driven and outputs sampled on negedge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_is_store_i (req_is_store),
        .req_funct3_i   (req_funct3),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_be_o       (bus_be),
        .bus_wdata_o    (bus_wdata),
        .bus_gnt_i      (bus_gnt),
        .bus_rvalid_i   (bus_rvalid),
        .bus_rdata_i    (bus_rdata),
        .resp_valid_o   (resp_valid),
        .resp_data_o    (resp_data),
        .resp_fault_o   (resp_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns at the negedge of cycle T+1.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    task automatic load_fast(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'h0);
        chk({tag, ".bus_req"}, bus_req, 1);
        chk({tag, ".bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        chk({tag, ".ready_busy"}, req_ready, 0);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk({tag, ".resp_valid"}, resp_valid, 1);
        chk({tag, ".resp_data"}, resp_data, exp);
        chk({tag, ".resp_fault"}, resp_fault, 0);
        @(negedge clk);
        chk({tag, ".pulse_end"}, resp_valid, 0);
    endtask

    task automatic expect_fault(input string tag, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr);
        issue(st, f3, addr, 32'hFFFF_FFFF);
        chk({tag, ".no_bus"}, bus_req, 0);
        chk({tag, ".resp_valid"}, resp_valid, 1);
        chk({tag, ".resp_fault"}, resp_fault, 1);
        chk({tag, ".resp_data"}, resp_data, 0);
        @(negedge clk);
        chk({tag, ".pulse_end"}, resp_valid, 0);
        chk({tag, ".ready"}, req_ready, 1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst.ready", req_ready, 1);
        chk("rst.bus_req", bus_req, 0);
        chk("rst.bus_we", bus_we, 0);
        chk("rst.bus_be", bus_be, 0);
        chk("rst.bus_addr", bus_addr, 0);
        chk("rst.bus_wdata", bus_wdata, 0);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.resp_data", resp_data, 0);
        chk("rst.resp_fault", resp_fault, 0);
        rst_n = 1'b1;

        // Spurious gnt/rvalid in IDLE
        @(negedge clk);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk("idle_spur.resp_valid", resp_valid, 0);
        chk("idle_spur.bus_req", bus_req, 0);

        // LW with bus field checks, then sub-word loads
        load_fast("lw", 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_fast("lb3", 3'b000, 32'h0000_1003, 32'h80FF_FF00, 32'hFFFF_FF80);
        load_fast("lbu3", 3'b100, 32'h0000_1003, 32'h80FF_FF00, 32'h0000_0080);
        load_fast("lb1", 3'b000, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F);
        load_fast("lh2", 3'b001, 32'h0000_1002, 32'h80FF_FF00, 32'hFFFF_80FF);
        load_fast("lhu0", 3'b101, 32'h0000_1000, 32'h1234_8001, 32'h0000_8001);

        // SH with delayed gnt and rvalid; spurious rvalid before gnt
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234);
        bus_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("sh.bus_req", bus_req, 1);
            chk("sh.bus_we", bus_we, 1);
            chk("sh.bus_addr", bus_addr, 32'h0000_2000);
            chk("sh.bus_be", bus_be, 4'b1100);
            chk("sh.bus_wdata", bus_wdata, 32'h1234_1234);
            chk("sh.no_resp", resp_valid, 0);
            if (i == 2) bus_gnt = 1'b1;
            @(negedge clk);
            bus_rvalid = 1'b0;
        end
        bus_gnt = 1'b0;
        chk("sh.wait_bus_req", bus_req, 0);
        chk("sh.wait_no_resp", resp_valid, 0);
        @(negedge clk);
        chk("sh.wait2_no_resp", resp_valid, 0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("sh.resp_valid", resp_valid, 1);
        chk("sh.resp_data", resp_data, 0);
        chk("sh.resp_fault", resp_fault, 0);
        @(negedge clk);
        chk("sh.pulse_end", resp_valid, 0);

        // SB lane 1
        issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB);
        chk("sb.bus_be", bus_be, 4'b0010);
        chk("sb.bus_wdata", bus_wdata, 32'hABAB_ABAB);
        chk("sb.bus_addr", bus_addr, 32'h0000_3000);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk("sb.resp_valid", resp_valid, 1);
        chk("sb.resp_data", resp_data, 0);
        @(negedge clk);

        // SW
        issue(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D);
        chk("sw.bus_be", bus_be, 4'b1111);
        chk("sw.bus_wdata", bus_wdata, 32'hCAFE_F00D);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk("sw.resp_valid", resp_valid, 1);
        @(negedge clk);

        // Fault paths
        expect_fault("lw_mis", 1'b0, 3'b010, 32'h0000_1001);
        expect_fault("ld_f3_011", 1'b0, 3'b011, 32'h0000_1000);
        expect_fault("lh_mis", 1'b0, 3'b001, 32'h0000_1003);
        expect_fault("sh_mis", 1'b1, 3'b001, 32'h0000_2001);
        expect_fault("st_f3_100", 1'b1, 3'b100, 32'h0000_2000);

        // Reset in REQ: bus_req must drop without a clock edge
        issue(1'b0, 3'b010, 32'h0000_6000, 32'h0);
        chk("rst_req.bus_req_before", bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req.bus_req_async", bus_req, 0);
        chk("rst_req.ready_async", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in WAIT, then a late rvalid
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("rst_wait.in_wait", bus_req, 0);
        chk("rst_wait.busy", req_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1111_2222;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("rst_wait.no_resp", resp_valid, 0);
        chk("rst_wait.ready", req_ready, 1);
        chk("rst_wait.bus_req", bus_req, 0);
        @(negedge clk);
        chk("rst_wait.no_resp2", resp_valid, 0);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: no gnt, fault after 8 cycles in REQ
        begin
            int k;
            issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
            k = 1;
            while (!resp_valid && k < 40) begin
                @(negedge clk);
                k++;
            end
            chk("tmo.latency", k, 9);
            chk("tmo.resp_fault", resp_fault, 1);
            chk("tmo.resp_data", resp_data, 0);
            chk("tmo.bus_req", bus_req, 0);
            bus_rvalid = 1'b1;
            @(negedge clk);
            bus_rvalid = 1'b0;
            chk("tmo.late_rvalid", resp_valid, 0);
            @(negedge clk);
            chk("tmo.late_rvalid2", resp_valid, 0);
            chk("tmo.ready", req_ready, 1);
        end
`else
        // Without the watchdog the request waits indefinitely
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        repeat (20) @(negedge clk);
        chk("nowd.bus_req", bus_req, 1);
        chk("nowd.no_resp", resp_valid, 0);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0000_0055;
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk("nowd.resp_valid", resp_valid, 1);
        chk("nowd.resp_data", resp_data, 32'h0000_0055);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage of the RV32 pipeline, directly upstream of the write-back select mux.
- Accepts one load/store request from execute and runs a single-outstanding data-bus transaction.
- Aligns and sign/zero-extends load data and presents it as the memory-path operand to write-back.

Parameters:
- TIMEOUT_CYCLES, 255: bus watchdog limit in cycles. Only used when LSU_TIMEOUT_EN is defined.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  execute presents a request.
- req_ready  output  1  LSU can accept; high only in IDLE.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 size/sign encoding.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data (rs2).
- bus_req  output  1  bus transaction request.
- bus_we  output  1  write enable.
- bus_addr  output  32  word-aligned address: req_addr with bits [1:0] forced to 00.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_gnt  input  1  bus accepted request.
- bus_rvalid  input  1  response/ack, including store ack.
- bus_rdata  input  32  raw read word.
- resp_valid  output  1  one-cycle completion pulse.
- resp_data  output  32  extended load data to write-back; 0 for stores and faults.
- resp_fault  output  1  misaligned, illegal funct3, or timeout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, resp_valid=0, resp_data=0, resp_fault=0. req_ready=1 (decoded from IDLE).
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE to REQ: on req_valid && req_ready with a legal, aligned request. All request fields are registered. Bus outputs are driven from registers.
- IDLE to RESP (fault, no bus activity): on acceptance of a misaligned or illegal request. Next cycle resp_fault=1, resp_data=0.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW. All other funct3 values are illegal.
- REQ: bus_req=1. addr/we/be/wdata are held stable until bus_gnt is sampled high.
  - gnt without rvalid: go to WAIT.
  - gnt and rvalid in the same cycle: capture the response, go to RESP.
- WAIT: bus_req=0. On bus_rvalid, capture the response and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_data/resp_fault are registered and valid only while resp_valid=1.
- Latency: accept at edge T gives bus_req high in cycle T+1. With same-cycle gnt/rvalid, resp_valid is high in cycle T+2, which is the minimum. A fault path gives resp_valid in cycle T+1.
- Stores:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = halfword replicated ×2.
  - SW: be = 1111.
- Loads: select byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Spurious input: bus_rvalid in IDLE or REQ before gnt is ignored. bus_gnt outside REQ is ignored.
- Reset mid-transaction: the transaction is abandoned and bus_req drops asynchronously. A late rvalid after reset is ignored in IDLE.
- No new request is accepted in REQ, WAIT or RESP (req_ready=0).

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES without completion:
  - go to RESP with resp_fault=1, resp_data=0, bus_req=0;
  - any later rvalid is ignored.
- Undefined: no counter; the FSM waits indefinitely for gnt/rvalid.

Decomposition:
- Package lsu_pkg:
  - lsu_state_t enum (IDLE, REQ, WAIT, RESP);
  - mem_funct3_t enum (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101);
  - constants for byte-enable patterns.
- Sub-module load_align: purely combinational lane select plus sign/zero extension from funct3, addr[1:0] and rdata. It is instantiated once on the captured read data.

Test Plan:
- LW addr 0x1000, gnt+rvalid same cycle, rdata 0xDEADBEEF -> bus_addr 0x1000, be 1111; resp_valid at T+2; resp_data 0xDEADBEEF, fault 0.
- LB addr 0x1003, rdata 0x80FF_FF00 -> resp_data 0xFFFFFF80. LBU addr 0x1003 -> 0x00000080.
- SH addr 0x2002, wdata 0x0000_1234, gnt after 3 cycles, rvalid 2 cycles later -> be 1100, wdata 0x12341234, bus fields stable through REQ; one resp_valid with resp_data 0.
- LW addr 0x1001 -> no bus_req; resp_valid at T+1 with resp_fault=1. funct3=011 load -> same.
- rst_n low while in WAIT, then rvalid after release -> state IDLE, bus_req=0, no resp_valid, req_ready=1.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8, gnt never asserted -> resp_valid with resp_fault=1 after 8 cycles in REQ; a subsequent rvalid is ignored.
